unit_bus: RTL
=============

# unit_bus

Execution datapath directly downstream of the instruction decoder. Consumes the decoder's one-hot target-enable (`ien`) and source-enable (`oen`) vectors and performs exactly one source→target move per accepted instruction. Owns the architectural registers (IR, PC, AR, DR0, DR1, CR) and runs a req/ack handshake to instruction/data memory. Feeds IR back to the decoder and raises `o_busy` while a memory move is outstanding; the decoder holds its state while `o_busy` is high.

## Interface
- `DATA_WIDTH`, 8: bus, register and memory data width (≥8; the decoder reads IR[7:0]).
- `ADDR_WIDTH`, 8: memory address width. PC and AR are the low `ADDR_WIDTH` bits of their registers.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_unit_ien` in 16: one-hot target select, decoder bit map.
- `i_unit_oen` in 16: one-hot source select, same bit map.
- `o_ins` out DATA_WIDTH: IR contents, to decoder.
- `o_busy` out 1: memory move in progress; ien/oen ignored.
- `o_mem_req`, `o_mem_we` out 1: memory request; write qualifier.
- `o_mem_addr` out ADDR_WIDTH; `o_mem_wdata` out DATA_WIDTH.
- `i_mem_rdata` in DATA_WIDTH; `i_mem_ack` in 1: one-cycle completion strobe.
- `o_alu_a`, `o_alu_b` out DATA_WIDTH: DR0, DR1.
- `i_alu_re`, `i_alu_ad` in DATA_WIDTH: ALU result and adder output.
- `i_oth_rdata` in; `o_oth_wdata` out DATA_WIDTH; `o_oth_we` out 1: peripheral port.
- `o_cr` out DATA_WIDTH: CR contents.

## Operation
- Bit map: 0 NULL, 1 IR, 2 PC, 3 AR, 4 DR0, 5 DR1, 6 CR, 7 NULL1, 8 ALU_RE, 9 ALU_AD, 10/11 reserved, 12 MEM_PC, 13 MEM_AR, 14 OTH, 15 NULL.
- An all-zero or multi-hot vector is treated as NULL. A NULL, NULL1, reserved or ALU source drives the bus to 0 (NULL, NULL1, reserved) or to the ALU input. ALU/NULL targets are write-ignored.
- Accept only when state is IDLE. Both vectors are latched on the accept edge.
- Register move (no MEM_* in either vector): the target register is loaded with the bus value on the accept edge. `o_oth_we` is a one-cycle combinational strobe when the target is OTH.
- FSM states: IDLE, RD, WR.
  - Source MEM_PC or MEM_AR → RD.
  - Else target MEM_AR → WR.
  - Target MEM_PC is illegal and write-ignored.
- RD: `o_mem_req`=1, `o_mem_we`=0, address = PC or AR.
  - On the `i_mem_ack` edge, `i_mem_rdata` is loaded into the target.
  - If the target is MEM_AR, the data is captured into the hold register and the FSM goes to WR; otherwise it returns to IDLE.
- WR: `o_mem_req`=1, `o_mem_we`=1, address AR, wdata = latched bus value or hold register. On ack → IDLE.
- PC increments by 1 (wrapping mod 2^ADDR_WIDTH) on completion of every MEM_PC read. If PC is also the target, the loaded value wins.
- `i_mem_ack` outside RD/WR is ignored.

## Timing
- Reset: all registers 0. `o_ins`=0, `o_busy`=0, `o_mem_req`=0, `o_mem_we`=0, `o_oth_we`=0, FSM IDLE.
- Register move: 1-cycle latency, never busy.
- Memory move: `o_busy` and `o_mem_req` are registered, high from accept+1 through the ack cycle inclusive. Minimum 2 cycles (ack in the first request cycle).
- Read-then-write: no idle cycle between RD ack and WR request.
- `o_mem_addr`, `o_mem_we` and `o_mem_wdata` are stable while `o_mem_req`=1.
- Reset mid-operation: FSM goes to IDLE on the reset edge. `o_mem_req` is low the next cycle. A late ack is ignored and the target is unchanged.

## Structure
- Shared `define.v` holds the unit codes, the one-hot enable constants and `DATA_WIDTH`; the decoder and `unit_bus` must both use them.
- One sub-module, `unit_src_mux`: combinational one-hot source selector producing the bus value.
- FSM, register file and handshake stay in `unit_bus`.

## Test plan
- Reset: assert `rst` 2 cycles → PC=0, `o_ins`=0, `o_busy`=0, `o_mem_req`=0.
- Fetch: oen bit12, ien bit1, memory acks 0x45 on the 2nd request cycle → `o_ins`=0x45, PC=1, `o_busy` high 2 cycles.
- Register move: DR0=0x3C, oen bit4, ien bit5 → DR1=0x3C next edge, `o_mem_req` never asserted.
- Store: AR=0x10, DR0=0xA5, oen bit4, ien bit13 → `o_mem_we`=1, addr 0x10, wdata 0xA5 held until ack.
- PC wrap and illegal vector: PC=0xFF, fetch → PC=0x00. Then oen=0x0030 (multi-hot), ien bit4 → DR0=0.
- Reset mid-read: assert `rst` during RD, ack one cycle later with 0x77 → `o_mem_req`=0 next cycle, IR stays 0, PC stays 0.

Source files
------------

// File: rtl/unit_bus_pkg.sv
// Shared unit codes and one-hot enable constants for the decoder and unit_bus.
package unit_bus_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 8;

    // Unit codes: bit positions inside the 16-bit ien/oen vectors.
    localparam int unsigned U_NULL   = 0;
    localparam int unsigned U_IR     = 1;
    localparam int unsigned U_PC     = 2;
    localparam int unsigned U_AR     = 3;
    localparam int unsigned U_DR0    = 4;
    localparam int unsigned U_DR1    = 5;
    localparam int unsigned U_CR     = 6;
    localparam int unsigned U_NULL1  = 7;
    localparam int unsigned U_ALU_RE = 8;
    localparam int unsigned U_ALU_AD = 9;
    localparam int unsigned U_MEM_PC = 12;
    localparam int unsigned U_MEM_AR = 13;
    localparam int unsigned U_OTH    = 14;
    localparam int unsigned U_NULL15 = 15;

    typedef logic [15:0] unit_en_t;

    localparam unit_en_t EN_NULL   = 16'h0001;
    localparam unit_en_t EN_IR     = 16'h0002;
    localparam unit_en_t EN_PC     = 16'h0004;
    localparam unit_en_t EN_AR     = 16'h0008;
    localparam unit_en_t EN_DR0    = 16'h0010;
    localparam unit_en_t EN_DR1    = 16'h0020;
    localparam unit_en_t EN_CR     = 16'h0040;
    localparam unit_en_t EN_NULL1  = 16'h0080;
    localparam unit_en_t EN_ALU_RE = 16'h0100;
    localparam unit_en_t EN_ALU_AD = 16'h0200;
    localparam unit_en_t EN_MEM_PC = 16'h1000;
    localparam unit_en_t EN_MEM_AR = 16'h2000;
    localparam unit_en_t EN_OTH    = 16'h4000;
    localparam unit_en_t EN_NULL15 = 16'h8000;

    // Anything that is not exactly one-hot collapses to the NULL unit.
    function automatic unit_en_t norm_en(input unit_en_t v);
        return $onehot(v) ? v : EN_NULL;
    endfunction

endpackage

// File: rtl/unit_src_mux.sv
// One-hot source selector: drives the internal bus from the selected unit.
module unit_src_mux
    import unit_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [15:0]           i_oen,
    input  logic [DATA_WIDTH-1:0] i_ir,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_ar,
    input  logic [DATA_WIDTH-1:0] i_dr0,
    input  logic [DATA_WIDTH-1:0] i_dr1,
    input  logic [DATA_WIDTH-1:0] i_cr,
    input  logic [DATA_WIDTH-1:0] i_alu_re,
    input  logic [DATA_WIDTH-1:0] i_alu_ad,
    input  logic [DATA_WIDTH-1:0] i_oth_rdata,
    output logic [DATA_WIDTH-1:0] o_bus
);

    // NULL, reserved and memory sources contribute nothing, so the bus reads 0.
    logic w_unused;
    assign w_unused = ^{i_oen[U_NULL], i_oen[U_NULL1], i_oen[11:10],
                        i_oen[U_MEM_PC], i_oen[U_MEM_AR], i_oen[U_NULL15]};

    // AND-OR mux; the caller guarantees i_oen is one-hot.
    assign o_bus = ({DATA_WIDTH{i_oen[U_IR]}}     & i_ir)
                 | ({DATA_WIDTH{i_oen[U_PC]}}     & i_pc)
                 | ({DATA_WIDTH{i_oen[U_AR]}}     & i_ar)
                 | ({DATA_WIDTH{i_oen[U_DR0]}}    & i_dr0)
                 | ({DATA_WIDTH{i_oen[U_DR1]}}    & i_dr1)
                 | ({DATA_WIDTH{i_oen[U_CR]}}     & i_cr)
                 | ({DATA_WIDTH{i_oen[U_ALU_RE]}} & i_alu_re)
                 | ({DATA_WIDTH{i_oen[U_ALU_AD]}} & i_alu_ad)
                 | ({DATA_WIDTH{i_oen[U_OTH]}}    & i_oth_rdata);

endmodule

// File: rtl/unit_bus.sv
// Execution datapath: one source->target move per accepted instruction,
// architectural registers, and the req/ack handshake to memory.
module unit_bus
    import unit_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           i_unit_ien,
    input  logic [15:0]           i_unit_oen,
    output logic [DATA_WIDTH-1:0] o_ins,
    output logic                  o_busy,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    input  logic [DATA_WIDTH-1:0] i_alu_re,
    input  logic [DATA_WIDTH-1:0] i_alu_ad,
    input  logic [DATA_WIDTH-1:0] i_oth_rdata,
    output logic [DATA_WIDTH-1:0] o_oth_wdata,
    output logic                  o_oth_we,
    output logic [DATA_WIDTH-1:0] o_cr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [1:0]            r_state;
    logic [15:0]           r_ien;
    logic                  r_rd_pc;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_ir, r_pc, r_ar, r_dr0, r_dr1, r_cr;

    logic [15:0]           w_oen, w_ien, w_ld;
    logic [DATA_WIDTH-1:0] w_bus, w_ld_data, w_pc_next;
    logic [ADDR_WIDTH-1:0] w_pc_lo_inc;
    logic                  w_idle, w_mem_src, w_rd_done, w_pc_inc;
    logic                  w_unused;

    assign w_oen     = norm_en(i_unit_oen);
    assign w_ien     = norm_en(i_unit_ien);
    assign w_idle    = (r_state == S_IDLE);
    assign w_mem_src = w_oen[U_MEM_PC] | w_oen[U_MEM_AR];
    assign w_rd_done = (r_state == S_RD) & i_mem_ack;
    assign w_pc_inc  = w_rd_done & r_rd_pc;

    // Increment in the address width so PC wraps mod 2^ADDR_WIDTH.
    assign w_pc_lo_inc = r_pc[ADDR_WIDTH-1:0] + 1'b1;
    assign w_pc_next   = DATA_WIDTH'(w_pc_lo_inc);

    unit_src_mux #(.DATA_WIDTH(DATA_WIDTH)) u_src_mux (
        .i_oen       (w_oen),
        .i_ir        (r_ir),
        .i_pc        (r_pc),
        .i_ar        (r_ar),
        .i_dr0       (r_dr0),
        .i_dr1       (r_dr1),
        .i_cr        (r_cr),
        .i_alu_re    (i_alu_re),
        .i_alu_ad    (i_alu_ad),
        .i_oth_rdata (i_oth_rdata),
        .o_bus       (w_bus)
    );

    // Load strobes: a register move loads on the accept edge, a read loads on its ack.
    always_comb begin
        w_ld      = '0;
        w_ld_data = w_bus;
        if (w_idle && !w_mem_src) begin
            w_ld = w_ien;
        end else if (w_rd_done) begin
            w_ld      = r_ien;
            w_ld_data = i_mem_rdata;
        end
    end

    assign w_unused = ^{w_ld[U_NULL], w_ld[U_NULL1], w_ld[11:8],
                        w_ld[U_MEM_PC], w_ld[U_MEM_AR], w_ld[U_NULL15],
                        r_pc[DATA_WIDTH-1:0], r_ar[DATA_WIDTH-1:0]};

    // Handshake FSM; vectors and bus value are latched on every idle (accept) edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ien   <= '0;
            r_rd_pc <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ien   <= w_ien;
                    r_rd_pc <= w_oen[U_MEM_PC];
                    r_wdata <= w_bus;
                    if (w_mem_src)
                        r_state <= S_RD;
                    else if (w_ien[U_MEM_AR])
                        r_state <= S_WR;
                end
                S_RD: begin
                    if (i_mem_ack) begin
                        if (r_ien[U_MEM_AR]) begin
                            r_wdata <= i_mem_rdata;
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WR: begin
                    if (i_mem_ack)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Architectural register file; a PC load takes priority over the fetch increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir  <= '0;
            r_pc  <= '0;
            r_ar  <= '0;
            r_dr0 <= '0;
            r_dr1 <= '0;
            r_cr  <= '0;
        end else begin
            if (w_ld[U_IR])  r_ir  <= w_ld_data;
            if (w_ld[U_AR])  r_ar  <= w_ld_data;
            if (w_ld[U_DR0]) r_dr0 <= w_ld_data;
            if (w_ld[U_DR1]) r_dr1 <= w_ld_data;
            if (w_ld[U_CR])  r_cr  <= w_ld_data;
            if (w_ld[U_PC])
                r_pc <= w_ld_data;
            else if (w_pc_inc)
                r_pc <= w_pc_next;
        end
    end

    assign o_busy      = ~w_idle;
    assign o_mem_req   = ~w_idle;
    assign o_mem_we    = (r_state == S_WR);
    assign o_mem_addr  = ((r_state == S_RD) && r_rd_pc) ? r_pc[ADDR_WIDTH-1:0]
                                                        : r_ar[ADDR_WIDTH-1:0];
    assign o_mem_wdata = r_wdata;
    assign o_oth_we    = w_ld[U_OTH];
    assign o_oth_wdata = w_ld_data;
    assign o_ins       = r_ir;
    assign o_alu_a     = r_dr0;
    assign o_alu_b     = r_dr1;
    assign o_cr        = r_cr;

endmodule
